// File: rtl/cordic_host.sv
// Host-side sequencer for a CORDIC coprocessor: reduces and folds the angle, issues one request, fixes the sign.
// Optional WAIT timeout is enabled with `define CORDIC_HOST_TIMEOUT_EN.
module cordic_host #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_angle,
  input  logic [15:0] cmd_another,
  input  logic [3:0]  cmd_select,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_err,
  output logic [15:0] cordic_angle,
  output logic [15:0] cordic_another,
  output logic [3:0]  cordic_select,
  output logic        cordic_valid,
  input  logic [15:0] cordic_out,
  input  logic        cordic_out_valid,
  output logic        busy
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         state;
  logic signed [16:0] a;
  logic [15:0]        another_q;
  logic [3:0]         sel_q;
  logic               neg;
  logic [8:0]         fold_f;
  logic [1:0]         quad;
  logic               neg_c;
  logic               sel_onehot;
  logic [15:0]        neg_out;

  assign cmd_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign cordic_valid = (state == S_ISSUE);
  assign res_valid    = (state == S_DONE);
  assign sel_onehot   = (cmd_select != 4'd0) && ((cmd_select & (cmd_select - 4'd1)) == 4'd0);

  // Fold is only consumed once a is in 0..359, so the low 9 bits suffice.
  always_comb begin
    fold_f = 9'd0;
    quad   = 2'd0;
    if (a[8:0] <= 9'd90) begin
      fold_f = a[8:0];
      quad   = 2'd0;
    end else if (a[8:0] <= 9'd180) begin
      fold_f = 9'd180 - a[8:0];
      quad   = 2'd1;
    end else if (a[8:0] <= 9'd270) begin
      fold_f = a[8:0] - 9'd180;
      quad   = 2'd2;
    end else begin
      fold_f = 9'd360 - a[8:0];
      quad   = 2'd3;
    end
  end

  // sin negative in Q2/Q3, cos in Q1/Q2, tan in Q1/Q3
  assign neg_c   = (sel_q[0] & quad[1]) | (sel_q[1] & (quad[0] ^ quad[1])) | (sel_q[2] & quad[0]);
  assign neg_out = (cordic_out == 16'h8000) ? 16'h7fff : (~cordic_out + 16'd1);

`ifdef CORDIC_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      a              <= '0;
      another_q      <= '0;
      sel_q          <= '0;
      neg            <= 1'b0;
      res_data       <= '0;
      res_err        <= 1'b0;
      cordic_angle   <= '0;
      cordic_another <= '0;
      cordic_select  <= '0;
`ifdef CORDIC_HOST_TIMEOUT_EN
      tmo_cnt        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          a         <= {cmd_angle[15], cmd_angle};
          another_q <= cmd_another;
          sel_q     <= cmd_select;
          if (sel_onehot) state <= S_REDUCE;
          else begin
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_REDUCE: begin
          if (sel_q[3]) begin
            cordic_angle   <= a[15:0];
            cordic_another <= another_q;
            cordic_select  <= sel_q;
            neg            <= 1'b0;
            state          <= S_ISSUE;
          end else if (a < 17'sd0) begin
            a <= a + 17'sd360;
          end else if (a >= 17'sd360) begin
            a <= a - 17'sd360;
          end else begin
            cordic_angle   <= {7'd0, fold_f};
            cordic_another <= another_q;
            cordic_select  <= sel_q;
            neg            <= neg_c;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef CORDIC_HOST_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (cordic_out_valid) begin
            res_data <= neg ? neg_out : cordic_out;
            res_err  <= 1'b0;
            state    <= S_DONE;
          end
`ifdef CORDIC_HOST_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            res_data <= '0;
            res_err  <= 1'b1;
            state    <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_DONE: if (res_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_host.sv
// Randomized bench for cordic_host with a modular-arithmetic reference model and a behavioural coprocessor.
module tb_cordic_host;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_angle, cmd_another;
  logic [3:0]  cmd_select;
  logic        res_valid, res_ready, res_err;
  logic [15:0] res_data;
  logic [15:0] cordic_angle, cordic_another;
  logic [3:0]  cordic_select;
  logic        cordic_valid;
  logic [15:0] cordic_out;
  logic        cordic_out_valid;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  cordic_host dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_angle(cmd_angle), .cmd_another(cmd_another), .cmd_select(cmd_select),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .cordic_angle(cordic_angle), .cordic_another(cordic_another),
    .cordic_select(cordic_select), .cordic_valid(cordic_valid),
    .cordic_out(cordic_out), .cordic_out_valid(cordic_out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected coprocessor angle and sign flip from the mathematical rules.
  function automatic void ref_model(input logic [15:0] ang, input logic [3:0] sel,
                                    output logic [15:0] f, output bit ng);
    int a;
    if (sel == 4'b1000) begin
      f  = ang;
      ng = 0;
    end else begin
      a = (($signed(ang) % 360) + 360) % 360;
      if (a <= 90)       begin f = 16'(a);       ng = 0; end
      else if (a <= 180) begin f = 16'(180 - a); ng = (sel == 4'b0010) || (sel == 4'b0100); end
      else if (a <= 270) begin f = 16'(a - 180); ng = (sel == 4'b0001) || (sel == 4'b0010); end
      else               begin f = 16'(360 - a); ng = (sel == 4'b0001) || (sel == 4'b0100); end
    end
  endfunction

  task automatic run_cmd(input logic [15:0] ang, input logic [15:0] oth, input logic [3:0] sel,
                         input logic [15:0] dout, input int lat, input int hold);
    logic [15:0] f, exp_d, d0;
    bit ng, ok, cv_any;
    bit good_sel;
    int v;
    good_sel = ($countones(sel) == 1);
    ref_model(ang, sel, f, ng);
    if (!good_sel) exp_d = 16'h0;
    else if (!ng) exp_d = dout;
    else exp_d = (dout == 16'h8000) ? 16'h7fff : 16'(-int'(dout));
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    cmd_valid = 1; cmd_angle = ang; cmd_another = oth; cmd_select = sel;
    @(negedge clk);
    cmd_valid = 0;
    if (good_sel) begin
      for (int i = 0; i < 200 && !cordic_valid; i++) @(negedge clk);
      chk("cv_seen", cordic_valid, 1);
      chk("cv_angle", cordic_angle, f);
      chk("cv_another", cordic_another, oth);
      chk("cv_select", cordic_select, sel);
      @(negedge clk);
      chk("cv_pulse", cordic_valid, 0);
      repeat (lat) @(negedge clk);
      chk("cv_hold", cordic_angle, f);
      cordic_out_valid = 1; cordic_out = dout;
      @(negedge clk);
      cordic_out_valid = 0; cordic_out = $urandom();
    end else begin
      cv_any = 0;
      for (int i = 0; i < 5; i++) begin
        if (cordic_valid) cv_any = 1;
        @(negedge clk);
      end
      chk("no_issue", cv_any, 0);
    end
    for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp_d);
    chk("res_err", res_err, !good_sel);
    d0 = res_data;
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== d0 || cmd_ready) ok = 0;
    end
    v = ok;
    if (hold > 0) chk("hold_stable", v, 1);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("ret_idle", cmd_ready, 1);
    chk("res_drop", res_valid, 0);
  endtask

  initial begin
    bit seen;
    logic [3:0] s;
    int r;
    rst = 1; cmd_valid = 0; cmd_angle = 0; cmd_another = 0; cmd_select = 0;
    res_ready = 0; cordic_out = 0; cordic_out_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", res_valid, 0);
    chk("rst_cvalid", cordic_valid, 0);
    chk("rst_angle", cordic_angle, 0);
    chk("rst_data", {res_err, res_data}, 0);
    rst = 0;
    @(negedge clk);

    run_cmd(16'd30,            16'd0, 4'b0001, 16'h0080, 1, 0);
    run_cmd(16'd210,           16'd0, 4'b0001, 16'h0080, 0, 0);
    run_cmd(16'hff88,          16'd0, 4'b0010, 16'h0080, 2, 0);   // -120
    run_cmd(16'h8000,          16'd0, 4'b0100, 16'h8000, 1, 0);   // -32768
    run_cmd(16'd135,           16'd0, 4'b0010, 16'h8000, 1, 0);
    run_cmd(16'd5,             16'd7, 4'b1000, 16'h1234, 3, 0);
    run_cmd(16'd45,            16'd0, 4'b0011, 16'h0000, 0, 0);
    run_cmd(16'd100,           16'd0, 4'b0001, 16'h4000, 1, 10);
    run_cmd(16'd90,            16'd0, 4'b0010, 16'h0001, 0, 0);
    run_cmd(16'd180,           16'd0, 4'b0100, 16'h0002, 0, 0);
    run_cmd(16'd270,           16'd0, 4'b0001, 16'h0003, 0, 0);
    run_cmd(16'd360,           16'd0, 4'b0100, 16'h0004, 0, 0);

    // Abort in WAIT, then a stale strobe must not produce a result.
    cmd_valid = 1; cmd_angle = 16'd45; cmd_select = 4'b0001;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 20 && !cordic_valid; i++) @(negedge clk);
    chk("abort_cv", cordic_valid, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_angle", cordic_angle, 0);
    rst = 0;
    cordic_out_valid = 1; cordic_out = 16'h1111;
    @(negedge clk);
    cordic_out_valid = 0;
    seen = 0;
    repeat (6) begin
      if (res_valid || cordic_valid) seen = 1;
      @(negedge clk);
    end
    chk("abort_nores", seen, 0);
    chk("abort_idle", cmd_ready, 1);

`ifdef CORDIC_HOST_TIMEOUT_EN
    cmd_valid = 1; cmd_angle = 16'd10; cmd_select = 4'b0001;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 20 && !cordic_valid; i++) @(negedge clk);
    @(negedge clk);
    repeat (63) @(negedge clk);
    chk("tmo_early", res_valid, 0);
    @(negedge clk);
    chk("tmo_valid", res_valid, 1);
    chk("tmo_err", {res_err, res_data}, 17'h10000);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
`endif

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      s = (r < 8) ? 4'(1 << (r % 4)) : 4'($urandom_range(0, 15));
      run_cmd(16'($urandom()), 16'($urandom()), s,
              ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom()),
              $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
